// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding, frame field sizes and the checksum helper.
package loader_pkg;

    typedef enum logic [2:0] {
        S_ADDR  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_BOOT  = 3'd4,
        S_RUN   = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // Running frame checksum: plain XOR over every accepted byte.
    function automatic logic [7:0] xor_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by the header and data phases.
// The completed word is presented combinationally with the 4th byte so the loader never stalls.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam int LW = $clog2(WORD_BYTES);
    localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);

    logic [LW-1:0] lane_r;
    logic [23:0]   part_r;

    // Lane counter and partial-word shift register (first byte ends up in bits 7:0).
    always_ff @(posedge clk_in) begin
        if (rst || clear) begin
            lane_r <= '0;
            part_r <= 24'h000000;
        end else if (push) begin
            lane_r <= lane_r + LW'(1);
            part_r <= {din, part_r[23:8]};
        end
    end

    assign word       = {din, part_r};
    assign word_ready = push && (lane_r == LAST_LANE);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream, writes it into imem,
// verifies the XOR checksum and then presets and releases the CPU.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int IMEM_AW    = 10
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               im_we,
    output logic [IMEM_AW-1:0] im_waddr,
    output logic [31:0]        im_wdata,
    output logic               hlt,
    output logic               preset,
    output logic [31:0]        start_addr,
    output logic               load_done,
    output logic               load_err
);

    state_t             state_r, state_next;
    logic               accept_s, push_s, clear_s, write_s;
    logic [31:0]        word_s;
    logic               word_ready_s;
    logic [32:0]        end_word_s;
    logic [31:0]        start_addr_r, count_r, word_idx_r;
    logic [7:0]         xor_r;
    logic               im_we_r, preset_r, hlt_r, load_done_r, load_err_r;
    logic [IMEM_AW-1:0] im_waddr_r;
    logic [31:0]        im_wdata_r;

    assign accept_s = byte_valid && byte_ready;
    assign push_s   = accept_s && (state_r != S_CHECK);
    assign clear_s  = (state_r == S_BOOT) || (state_r == S_RUN) || (state_r == S_ERROR);
    // 33-bit sum so a huge N cannot wrap past the bound check.
    assign end_word_s = {3'b000, start_addr_r[31:2]} + {1'b0, word_s};

    byte_packer u_packer (
        .clk_in     (clk_in),
        .rst        (rst),
        .clear      (clear_s),
        .push       (push_s),
        .din        (byte_data),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // Byte acceptance is a pure decode of the current state.
    always_comb begin
        byte_ready = 1'b0;
        case (state_r)
            S_ADDR, S_COUNT, S_DATA, S_CHECK: byte_ready = 1'b1;
            default:                          byte_ready = 1'b0;
        endcase
    end

    // Next-state decode and imem write request.
    always_comb begin
        state_next = state_r;
        write_s    = 1'b0;
        case (state_r)
            S_ADDR: begin
                if (word_ready_s) begin
                    state_next = (word_s[1:0] != 2'b00) ? S_ERROR : S_COUNT;
                end else begin
                    state_next = state_r;
                end
            end
            S_COUNT: begin
                if (!word_ready_s) begin
                    state_next = state_r;
                end else if (word_s == 32'd0) begin
                    state_next = S_CHECK;
                end else if (end_word_s > 33'(IMEM_WORDS)) begin
                    state_next = S_ERROR;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_ready_s) begin
                    write_s    = 1'b1;
                    state_next = (word_idx_r == count_r - 32'd1) ? S_CHECK : S_DATA;
                end else begin
                    state_next = state_r;
                end
            end
            S_CHECK: begin
                if (accept_s) begin
                    state_next = (byte_data == xor_r) ? S_BOOT : S_ERROR;
                end else begin
                    state_next = state_r;
                end
            end
            S_BOOT:  state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase
    end

    // State, header fields, checksum and registered CPU/imem outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r      <= S_ADDR;
            start_addr_r <= 32'd0;
            count_r      <= 32'd0;
            word_idx_r   <= 32'd0;
            xor_r        <= 8'h00;
            im_we_r      <= 1'b0;
            im_waddr_r   <= '0;
            im_wdata_r   <= 32'd0;
            preset_r     <= 1'b0;
            hlt_r        <= 1'b1;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            state_r <= state_next;
            if (push_s) begin
                xor_r <= xor_next(xor_r, byte_data);
            end
            if ((state_r == S_ADDR) && word_ready_s) begin
                start_addr_r <= word_s;
            end
            if ((state_r == S_COUNT) && word_ready_s) begin
                count_r    <= word_s;
                word_idx_r <= 32'd0;
            end
            if (write_s) begin
                word_idx_r <= word_idx_r + 32'd1;
                im_waddr_r <= start_addr_r[IMEM_AW+1:2] + word_idx_r[IMEM_AW-1:0];
                im_wdata_r <= word_s;
            end
            im_we_r     <= write_s;
            preset_r    <= (state_next == S_BOOT);
            hlt_r       <= (state_next != S_RUN);
            load_done_r <= (state_next == S_RUN);
            load_err_r  <= (state_next == S_ERROR);
        end
    end

    assign im_we      = im_we_r;
    assign im_waddr   = im_waddr_r;
    assign im_wdata   = im_wdata_r;
    assign preset     = preset_r;
    assign hlt        = hlt_r;
    assign start_addr = start_addr_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected imem writes and PC presets are queued
// as frames are issued, and a negedge monitor pops and compares them.
module tb_prog_loader;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [9:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        hlt;
    logic        preset;
    logic [31:0] start_addr;
    logic        load_done;
    logic        load_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [41:0] exp_wq[$];
    logic [31:0] exp_pq[$];
    logic [7:0]  frame[$];

    prog_loader #(.IMEM_WORDS(1024), .IMEM_AW(10)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .hlt        (hlt),
        .preset     (preset),
        .start_addr (start_addr),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every write / preset the DUT presents must match the head of its queue.
    always @(negedge clk_in) begin
        if (rst === 1'b0) begin
            if (im_we) begin
                if (exp_wq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", im_waddr, im_wdata);
                end else begin
                    check("imem_write", {22'd0, im_waddr, im_wdata}, {22'd0, exp_wq.pop_front()});
                end
            end
            if (preset) begin
                if (exp_pq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_preset: got start_addr %h expected no preset", start_addr);
                end else begin
                    check("preset_addr_hlt", {31'd0, hlt, start_addr}, {31'd0, 1'b1, exp_pq.pop_front()});
                end
            end
        end
    end

    task automatic add_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) frame.push_back(w[8*k +: 8]);
    endtask

    task automatic build_nominal(input logic [7:0] chk);
        frame.delete();
        add_word(32'h00000000);
        add_word(32'h00000002);
        add_word(32'h00500093);
        add_word(32'h00100113);
        frame.push_back(chk);
    endtask

    // Each byte is offered for exactly one cycle; the loader never stalls while accepting.
    task automatic send_frame(input int nbytes, input int maxgap);
        int lim;
        lim = (nbytes < 0) ? frame.size() : nbytes;
        for (int i = 0; i < lim; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                byte_valid = 1'b0;
                @(negedge clk_in);
            end
            byte_valid = 1'b1;
            byte_data  = frame[i];
            @(negedge clk_in);
            byte_valid = 1'b0;
        end
    endtask

    // Status vector: {byte_ready, hlt, im_we, preset, load_done, load_err}.
    task automatic check_status(input string nm, input logic [5:0] exp_st, input logic [31:0] exp_sa);
        repeat (3) @(negedge clk_in);
        check({nm, "_status"}, {58'd0, byte_ready, hlt, im_we, preset, load_done, load_err}, {58'd0, exp_st});
        check({nm, "_start_addr"}, {32'd0, start_addr}, {32'd0, exp_sa});
        check({nm, "_writes_left"}, 64'(exp_wq.size()), 64'd0);
        check({nm, "_presets_left"}, 64'(exp_pq.size()), 64'd0);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        check({nm, "_reset_outs"}, {22'd0, byte_ready, hlt, im_we, preset, load_done, load_err, im_waddr, im_wdata},
              {22'd0, 6'b110000, 10'd0, 32'd0});
        check({nm, "_reset_sa"}, {32'd0, start_addr}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk_in);
        do_reset("init");

        // Nominal load, back-to-back bytes; later bytes in RUN are ignored.
        exp_wq.push_back({10'd0, 32'h00500093});
        exp_wq.push_back({10'd1, 32'h00100113});
        exp_pq.push_back(32'h00000000);
        build_nominal(8'hC3);
        send_frame(-1, 0);
        check_status("nominal", 6'b000010, 32'h00000000);
        frame.delete();
        add_word(32'h11223344);
        send_frame(-1, 0);
        check_status("run_ignores", 6'b000010, 32'h00000000);

        // Bad checksum: words still written, CPU stays halted.
        do_reset("badchk");
        exp_wq.push_back({10'd0, 32'h00500093});
        exp_wq.push_back({10'd1, 32'h00100113});
        build_nominal(8'hC2);
        send_frame(-1, 0);
        check_status("badchk", 6'b010001, 32'h00000000);

        // Misaligned start address.
        do_reset("misalign");
        build_nominal(8'hC1);
        frame[0] = 8'h02;
        send_frame(-1, 0);
        check_status("misalign", 6'b010001, 32'h00000002);

        // Image would run past the end of imem.
        do_reset("bounds");
        frame.delete();
        add_word(32'h00000FFC);
        add_word(32'h00000002);
        add_word(32'h00500093);
        add_word(32'h00100113);
        frame.push_back(8'h00);
        send_frame(-1, 0);
        check_status("bounds", 6'b010001, 32'h00000FFC);

        // Empty image goes straight to the checksum.
        do_reset("n_zero");
        exp_pq.push_back(32'h00000010);
        frame.delete();
        add_word(32'h00000010);
        add_word(32'h00000000);
        frame.push_back(8'h10);
        send_frame(-1, 0);
        check_status("n_zero", 6'b000010, 32'h00000010);

        // Gapped stream must give identical writes.
        do_reset("gapped");
        exp_wq.push_back({10'd0, 32'h00500093});
        exp_wq.push_back({10'd1, 32'h00100113});
        exp_pq.push_back(32'h00000000);
        build_nominal(8'hC3);
        send_frame(-1, 3);
        check_status("gapped", 6'b000010, 32'h00000000);

        // Reset in DATA after the first word, then a clean gapped reload.
        do_reset("midreset_pre");
        exp_wq.push_back({10'd0, 32'h00500093});
        build_nominal(8'hC3);
        send_frame(14, 1);
        @(negedge clk_in);
        check("midreset_first_write", 64'(exp_wq.size()), 64'd0);
        do_reset("midreset");
        exp_wq.push_back({10'd0, 32'h00500093});
        exp_wq.push_back({10'd1, 32'h00100113});
        exp_pq.push_back(32'h00000000);
        build_nominal(8'hC3);
        send_frame(-1, 2);
        check_status("reload", 6'b000010, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
